// File: rtl/ram40_arb_pkg.sv
// Shared types and constants for the two-requester SB_RAM40_4K controller.
package ram40_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Requester index: 0 or 1.
    typedef logic req_id_t;

    // Highest word address for a given address width.
    function automatic int init_last(input int aw);
        return (1 << aw) - 1;
    endfunction

    localparam int INIT_LAST = init_last(ADDR_W_DEF);

endpackage

// File: rtl/ram40_arbiter_if.sv
// Client-side bundle: two request/response channels plus the init status flag.
interface ram40_arbiter_if
    import ram40_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              req_0;
    logic              req_1;
    logic              wr_0;
    logic              wr_1;
    logic [ADDR_W-1:0] addr_0;
    logic [ADDR_W-1:0] addr_1;
    logic [DATA_W-1:0] wdata_0;
    logic [DATA_W-1:0] wdata_1;
    logic [DATA_W-1:0] mask_0;
    logic [DATA_W-1:0] mask_1;
    logic              gnt_0;
    logic              gnt_1;
    logic              rvalid_0;
    logic              rvalid_1;
    logic [DATA_W-1:0] rdata_0;
    logic [DATA_W-1:0] rdata_1;
    logic              init_done;

    // Client logic drives requests and consumes grants/read data.
    modport master (
        output req_0, req_1, wr_0, wr_1, addr_0, addr_1,
               wdata_0, wdata_1, mask_0, mask_1,
        input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1, init_done
    );

    // The arbiter sees the mirror image.
    modport slave (
        input  req_0, req_1, wr_0, wr_1, addr_0, addr_1,
               wdata_0, wdata_1, mask_0, mask_1,
        output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1, init_done
    );

endinterface

// File: rtl/ram40_rr_arb.sv
// Two-way grant logic: round-robin or fixed priority, with the last accepted
// winner remembered so a contested cycle alternates fairly.
module ram40_rr_arb
    import ram40_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output req_id_t    sel
);

    req_id_t last_gnt;

    // Pick the winner; with no request, sel stays on the previous winner so
    // the RAM address/data lines do not toggle needlessly.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
        gnt = 2'b00;
        sel = last_gnt;
        case (req)
            2'b01: begin
                sel = 1'b0;
                gnt = 2'b01;
            end
            2'b10: begin
                sel = 1'b1;
                gnt = 2'b10;
            end
            2'b11: begin
                sel = FIXED_PRIO ? 1'b0 : ~last_gnt;
                gnt = sel ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    // Track the last accepted winner; idle cycles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (accept) begin
            last_gnt <= sel;
        end
    end

endmodule

// File: rtl/ram40_arbiter.sv
// Two-requester controller for one SB_RAM40_4K (256x16, mode 0). Clears the
// RAM after reset when INIT_CLEAR is set, then grants one access per cycle
// and returns registered read data to whichever requester asked for it.
module ram40_arbiter
    import ram40_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit INIT_CLEAR = 1'b1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    ram40_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_mask,
    output logic              ram_we,
    output logic              ram_wclke,
    output logic              ram_re,
    output logic              ram_rclke,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(init_last(ADDR_W));
    localparam state_t            RESET_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              init_done_q;

    logic              serve;
    logic              init_we;
    logic [1:0]        req_run;
    logic [1:0]        gnt;
    req_id_t           sel;
    logic              accept;
    logic              sel_wr;

    logic              tag_valid;
    req_id_t           tag_id;
    logic              rvalid_0_q;
    logic              rvalid_1_q;
    logic [DATA_W-1:0] rdata_0_q;
    logic [DATA_W-1:0] rdata_1_q;

    assign serve   = (state == ST_RUN) && !rst;
    assign init_we = (state == ST_INIT) && !rst;
    assign req_run = {bus.req_1, bus.req_0} & {2{serve}};
    assign accept  = |gnt;
    assign sel_wr  = sel ? bus.wr_1 : bus.wr_0;

    ram40_rr_arb #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_run),
        .accept (accept),
        .gnt    (gnt),
        .sel    (sel)
    );

    // Init sequencer: sweep every word once, then serve requests until reset.
    // NOTE: the RAM array itself cannot be reset, so it is cleared by writing zeros here rather than by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RESET_STATE;
            init_cnt    <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + ADDR_W'(1);
                    if (init_cnt == LAST_ADDR) begin
                        state       <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state <= RESET_STATE;
                end
            endcase
        end
    end

    // RAM port mux: init clear overrides, otherwise the current winner drives.
    always_comb begin
        ram_waddr = sel ? bus.addr_1  : bus.addr_0;
        ram_raddr = sel ? bus.addr_1  : bus.addr_0;
        ram_wdata = sel ? bus.wdata_1 : bus.wdata_0;
        ram_mask  = sel ? bus.mask_1  : bus.mask_0;
        ram_we    = accept && sel_wr;
        ram_re    = accept && !sel_wr;
        if (init_we) begin
            ram_waddr = init_cnt;
            ram_wdata = '0;
            ram_mask  = '0;
            ram_we    = 1'b1;
            ram_re    = 1'b0;
        end
    end

    assign ram_wclke = ram_we;
    assign ram_rclke = ram_re;

    // Read return: tag the accepted read, capture primitive data one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid  <= 1'b0;
            tag_id     <= 1'b0;
            rvalid_0_q <= 1'b0;
            rvalid_1_q <= 1'b0;
            rdata_0_q  <= '0;
            rdata_1_q  <= '0;
        end else begin
            tag_valid  <= ram_re;
            tag_id     <= sel;
            rvalid_0_q <= tag_valid && !tag_id;
            rvalid_1_q <= tag_valid && tag_id;
            if (tag_valid && !tag_id) begin
                rdata_0_q <= ram_rdata;
            end
            if (tag_valid && tag_id) begin
                rdata_1_q <= ram_rdata;
            end
        end
    end

    assign bus.gnt_0     = gnt[0];
    assign bus.gnt_1     = gnt[1];
    assign bus.rvalid_0  = rvalid_0_q;
    assign bus.rvalid_1  = rvalid_1_q;
    assign bus.rdata_0   = rdata_0_q;
    assign bus.rdata_1   = rdata_1_q;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_ram40_arbiter.sv
// Bench for ram40_arbiter: a round-robin instance with init clear is checked
// every cycle against a transaction-level model; a fixed-priority instance
// is used for the priority case. Both drive behavioural RAM models.
module tb_ram40_arbiter;
    import ram40_arb_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- DUT A: round-robin, init clear ----------------
    ram40_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    logic [AW-1:0] waddr_a, raddr_a;
    logic [DW-1:0] wdata_a, mask_a, rdata_ram_a;
    logic          we_a, wclke_a, re_a, rclke_a;

    ram40_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_CLEAR(1'b1), .FIXED_PRIO(1'b0)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_a),
        .ram_waddr (waddr_a),
        .ram_raddr (raddr_a),
        .ram_wdata (wdata_a),
        .ram_mask  (mask_a),
        .ram_we    (we_a),
        .ram_wclke (wclke_a),
        .ram_re    (re_a),
        .ram_rclke (rclke_a),
        .ram_rdata (rdata_ram_a)
    );

    // ---------------- DUT B: fixed priority, no init ----------------
    ram40_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
    logic [AW-1:0] waddr_b, raddr_b;
    logic [DW-1:0] wdata_b, mask_b, rdata_ram_b;
    logic          we_b, wclke_b, re_b, rclke_b;

    ram40_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_CLEAR(1'b0), .FIXED_PRIO(1'b1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_b),
        .ram_waddr (waddr_b),
        .ram_raddr (raddr_b),
        .ram_wdata (wdata_b),
        .ram_mask  (mask_b),
        .ram_we    (we_b),
        .ram_wclke (wclke_b),
        .ram_re    (re_b),
        .ram_rclke (rclke_b),
        .ram_rdata (rdata_ram_b)
    );

    // Behavioural SB_RAM40_4K models (mode 0, mask bit 1 = keep old bit).
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_a[i] = 16'hBEEF ^ 16'(i);
        rdata_ram_a = '0;
        forever begin
            @(posedge clk);
            if (re_a && rclke_a) rdata_ram_a <= mem_a[raddr_a];
            if (we_a && wclke_a) mem_a[waddr_a] = (mem_a[waddr_a] & mask_a) | (wdata_a & ~mask_a);
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_b[i] = '0;
        rdata_ram_b = '0;
        forever begin
            @(posedge clk);
            if (re_b && rclke_b) rdata_ram_b <= mem_b[raddr_b];
            if (we_b && wclke_b) mem_b[waddr_b] = (mem_b[waddr_b] & mask_b) | (wdata_b & ~mask_b);
        end
    end

    // ---------------- Transaction-level model of DUT A ----------------
    typedef struct {
        int            id;
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] m_rd [2];
    int            m_edges = 0;
    int            m_last  = 1;
    int            cyc     = 0;
    int            m_win;
    bit            m_run;
    logic [1:0]    m_req, m_gnt, m_rv;
    logic          m_wr;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d, m_m;

    always @(negedge clk) begin
        if (rst) begin
            m_edges = 0;
            m_last  = 1;
            pend.delete();
            m_rd[0] = '0;
            m_rd[1] = '0;
            check("rst_gnt",       32'({bus_a.gnt_1, bus_a.gnt_0}), 0);
            check("rst_rvalid",    32'({bus_a.rvalid_1, bus_a.rvalid_0}), 0);
            check("rst_rdata_0",   32'(bus_a.rdata_0), 0);
            check("rst_rdata_1",   32'(bus_a.rdata_1), 0);
            check("rst_init_done", 32'(bus_a.init_done), 0);
            check("rst_we_re",     32'({we_a, re_a}), 0);
        end else begin
            m_rv = 2'b00;
            while (pend.size() > 0 && pend[0].due == cyc) begin
                m_rd[pend[0].id] = pend[0].data;
                m_rv[pend[0].id] = 1'b1;
                void'(pend.pop_front());
            end
            m_run = (m_edges >= DEPTH);
            m_req = m_run ? {bus_a.req_1, bus_a.req_0} : 2'b00;
            m_win = -1;
            if (m_req == 2'b11)  m_win = (m_last == 0) ? 1 : 0;
            else if (m_req[0])   m_win = 0;
            else if (m_req[1])   m_win = 1;
            m_gnt = 2'b00;
            if (m_win >= 0) m_gnt[m_win] = 1'b1;

            check("gnt",       32'({bus_a.gnt_1, bus_a.gnt_0}), 32'(m_gnt));
            check("rvalid",    32'({bus_a.rvalid_1, bus_a.rvalid_0}), 32'(m_rv));
            check("rdata_0",   32'(bus_a.rdata_0), 32'(m_rd[0]));
            check("rdata_1",   32'(bus_a.rdata_1), 32'(m_rd[1]));
            check("init_done", 32'(bus_a.init_done), 32'(m_run));

            if (!m_run) begin
                check("init_we_re",  32'({we_a, re_a}), 32'(2'b10));
                check("init_waddr",  32'(waddr_a), 32'(m_edges));
                check("init_wdata",  32'({wdata_a, mask_a}), 0);
            end else if (m_win < 0) begin
                check("idle_we_re",  32'({we_a, re_a}), 0);
            end else begin
                m_wr = (m_win == 1) ? bus_a.wr_1    : bus_a.wr_0;
                m_a  = (m_win == 1) ? bus_a.addr_1  : bus_a.addr_0;
                m_d  = (m_win == 1) ? bus_a.wdata_1 : bus_a.wdata_0;
                m_m  = (m_win == 1) ? bus_a.mask_1  : bus_a.mask_0;
                check("acc_we_re", 32'({we_a, re_a}), 32'({m_wr, !m_wr}));
                if (m_wr) begin
                    check("wr_addr", 32'(waddr_a), 32'(m_a));
                    check("wr_data", 32'(wdata_a), 32'(m_d));
                    check("wr_mask", 32'(mask_a),  32'(m_m));
                    ref_mem[m_a] = (ref_mem[m_a] & m_m) | (m_d & ~m_m);
                end else begin
                    check("rd_addr", 32'(raddr_a), 32'(m_a));
                    pend.push_back('{m_win, cyc + 2, ref_mem[m_a]});
                end
                m_last = m_win;
            end

            if (!m_run) begin
                m_edges++;
                if (m_edges == DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
                end
            end
        end
        cyc++;
    end

    // ---------------- Stimulus helpers ----------------
    task automatic set_a(input int id, input logic rq, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
        if (id == 0) begin
            bus_a.req_0 = rq; bus_a.wr_0 = wr; bus_a.addr_0 = a; bus_a.wdata_0 = d; bus_a.mask_0 = m;
        end else begin
            bus_a.req_1 = rq; bus_a.wr_1 = wr; bus_a.addr_1 = a; bus_a.wdata_1 = d; bus_a.mask_1 = m;
        end
    endtask

    // Entered and left 2 time units after a rising edge; holds REQ until granted.
    task automatic do_req(input int id, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
        bit got = 1'b0;
        set_a(id, 1'b1, wr, a, d, m);
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            got = (id == 0) ? bus_a.gnt_0 : bus_a.gnt_1;
            @(posedge clk); #2;
        end
        if (!got) fail_now($sformatf("grant_timeout_req%0d", id));
        set_a(id, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- Directed sequence ----------------
    initial begin
        int         cnt;
        int         nz;
        int         fp0, fp1;
        logic [5:0] gseq;
        bit         done;

        set_a(0, 1'b0, 1'b0, '0, '0, '0);
        set_a(1, 1'b0, 1'b0, '0, '0, '0);
        bus_b.req_0 = 1'b0; bus_b.wr_0 = 1'b1; bus_b.addr_0 = 8'h40; bus_b.wdata_0 = 16'h0040; bus_b.mask_0 = '0;
        bus_b.req_1 = 1'b0; bus_b.wr_1 = 1'b1; bus_b.addr_1 = 8'h41; bus_b.wdata_1 = 16'h0041; bus_b.mask_1 = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        // Init: read of 0x00 pending throughout; INIT_DONE after 256 edges.
        set_a(0, 1'b1, 1'b0, 8'h00, '0, '0);
        rst = 1'b0;
        cnt = 0;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (bus_a.init_done) done = 1'b1;
            else cnt++;
        end
        check("init_done_latency", 32'(cnt), 256);
        check("first_run_gnt_0", 32'(bus_a.gnt_0), 1);
        @(posedge clk); #2;
        set_a(0, 1'b0, 1'b0, '0, '0, '0);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem_a[i] !== '0) nz++;
        check("init_nonzero_words", 32'(nz), 0);

        // Write then read from the other requester.
        do_req(0, 1'b1, 8'h12, 16'hA5A5, 16'h0000);
        do_req(1, 1'b0, 8'h12, '0, '0);
        @(negedge clk);
        check("rd1_rvalid_early", 32'(bus_a.rvalid_1), 0);
        @(negedge clk);
        check("rd1_rvalid", 32'(bus_a.rvalid_1), 1);
        check("rd1_data", 32'(bus_a.rdata_1), 32'h0000_A5A5);
        check("rd1_rdata_0_held", 32'(bus_a.rdata_0), 0);
        @(posedge clk); #2;

        // Masked write: upper byte preserved.
        do_req(0, 1'b1, 8'h12, 16'hFFFF, 16'hFF00);
        do_req(0, 1'b0, 8'h12, '0, '0);
        @(negedge clk);
        @(negedge clk);
        check("masked_rvalid_0", 32'(bus_a.rvalid_0), 1);
        check("masked_data", 32'(bus_a.rdata_0), 32'h0000_A5FF);
        @(posedge clk); #2;

        // Contention: requester 1 wins last, then both held for 6 cycles.
        do_req(1, 1'b1, 8'h81, 16'h0000, 16'h0000);
        set_a(0, 1'b1, 1'b1, 8'h80, 16'h0080, '0);
        set_a(1, 1'b1, 1'b1, 8'h81, 16'h0081, '0);
        bus_b.req_0 = 1'b1;
        bus_b.req_1 = 1'b1;
        gseq = '0; fp0 = 0; fp1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            gseq[k] = bus_a.gnt_1;
            if (bus_b.gnt_0) fp0++;
            if (bus_b.gnt_1) fp1++;
            @(posedge clk); #2;
        end
        set_a(0, 1'b0, 1'b0, '0, '0, '0);
        set_a(1, 1'b0, 1'b0, '0, '0, '0);
        bus_b.req_0 = 1'b0;
        bus_b.req_1 = 1'b0;
        check("rr_grant_seq", 32'(gseq), 32'(6'b101010));
        check("fp_grants_0", 32'(fp0), 6);
        check("fp_grants_1", 32'(fp1), 0);

        // Back-to-back reads R0@1, R1@2, R0@3.
        do_req(0, 1'b1, 8'h01, 16'h1111, '0);
        do_req(0, 1'b1, 8'h02, 16'h2222, '0);
        do_req(0, 1'b1, 8'h03, 16'h3333, '0);
        set_a(0, 1'b1, 1'b0, 8'h01, '0, '0);
        @(negedge clk);
        check("b2b_gnt_a", 32'(bus_a.gnt_0), 1);
        @(posedge clk); #2;
        set_a(0, 1'b0, 1'b0, '0, '0, '0);
        set_a(1, 1'b1, 1'b0, 8'h02, '0, '0);
        @(negedge clk);
        check("b2b_gnt_b", 32'(bus_a.gnt_1), 1);
        @(posedge clk); #2;
        set_a(1, 1'b0, 1'b0, '0, '0, '0);
        set_a(0, 1'b1, 1'b0, 8'h03, '0, '0);
        @(negedge clk);
        check("b2b_gnt_c", 32'(bus_a.gnt_0), 1);
        check("b2b_rv0_first", 32'(bus_a.rvalid_0), 1);
        check("b2b_data_1111", 32'(bus_a.rdata_0), 32'h0000_1111);
        @(posedge clk); #2;
        set_a(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("b2b_rv_1", 32'({bus_a.rvalid_1, bus_a.rvalid_0}), 32'(2'b10));
        check("b2b_data_2222", 32'(bus_a.rdata_1), 32'h0000_2222);
        @(negedge clk);
        check("b2b_rv0_second", 32'(bus_a.rvalid_0), 1);
        check("b2b_data_3333", 32'(bus_a.rdata_0), 32'h0000_3333);
        @(posedge clk); #2;

        // Reset with a read in flight.
        do_req(1, 1'b0, 8'h12, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_flight_rvalid", 32'({bus_a.rvalid_1, bus_a.rvalid_0}), 0);
        check("rst_flight_rdata", 32'({bus_a.rdata_1, bus_a.rdata_0}), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("reinit_we", 32'(we_a), 1);
        check("reinit_addr0", 32'(waddr_a), 0);
        check("reinit_rvalid", 32'(bus_a.rvalid_1), 0);
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            done = bus_a.init_done;
        end
        if (!done) fail_now("reinit_timeout");

        @(posedge clk); #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram40_arbiter.md
Name: ram40_arbiter

Overview:
- Two-requester controller sharing one SB_RAM40_4K configured as 256x16 (READ_MODE 0, WRITE_MODE 0, bit-masked writes).
- After reset, an optional init FSM clears the whole RAM.
- Then grants one access per cycle by round-robin or fixed priority, drives the RAM port signals, and returns registered read data per requester.
- Sits between client logic and the RAM primitive; the RAM is instantiated by the parent, so the benches use a behavioural RAM model.

Parameters:
- ADDR_W, 8, RAM address width (mode 0 depth 256).
- DATA_W, 16, data/mask width.
- INIT_CLEAR, 1, 1 = zero all words after reset before serving requests; 0 = serve immediately.
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins.

Ports:
- CLK  in  1  single clock; also the RAM WCLK/RCLK.
- RST  in  1  asynchronous reset, active high.
- REQ_0, REQ_1  in  1  access request, held until granted.
- WR_0, WR_1  in  1  1 = write, 0 = read.
- ADDR_0, ADDR_1  in  ADDR_W  word address.
- WDATA_0, WDATA_1  in  DATA_W  write data.
- MASK_0, MASK_1  in  DATA_W  write mask; 1 = bit NOT written (primitive polarity).
- GNT_0, GNT_1  out  1  combinational grant; transfer occurs on the edge where REQ&GNT=1.
- RVALID_0, RVALID_1  out  1  one-cycle pulse, RDATA_n updated this cycle.
- RDATA_0, RDATA_1  out  DATA_W  registered read data, held until that requester's next read.
- INIT_DONE  out  1  high once in RUN.
- RAM_WADDR, RAM_RADDR  out  ADDR_W  to primitive.
- RAM_WDATA, RAM_MASK  out  DATA_W  to primitive.
- RAM_WE, RAM_WCLKE, RAM_RE, RAM_RCLKE  out  1  to primitive (WCLKE=WE, RCLKE=RE).
- RAM_RDATA  in  DATA_W  from primitive.

Behaviour:
Reset values (all asynchronous):
- GNT_n, RVALID_n, RAM_WE/RE/CLKEs, INIT_DONE = 0.
- RDATA_n = 0; init counter = 0; last_gnt = 1 (requester 0 favoured first).
- State = INIT if INIT_CLEAR else RUN.

FSM, state INIT:
- RAM_WE=1, RAM_WADDR=counter, RAM_WDATA=0, RAM_MASK=0.
- Counter increments each cycle; at 255 → RUN next cycle. Exactly 256 write cycles.
- GNT_n=0 and INIT_DONE=0 throughout.

FSM, state RUN:
- INIT_DONE=1. Stays in RUN until RST.

Arbitration (RUN only, combinational):
- One requester → grant it.
- Both requesting → grant requester != last_gnt (round-robin) or requester 0 (FIXED_PRIO).
- last_gnt updates only on an accepted transfer.
- Idle cycles do not change last_gnt. At most one GNT high.

RAM drive:
- Granted write → RAM_WE=1, RAM_WADDR/RAM_WDATA/RAM_MASK from the winner, RAM_RE=0.
- Granted read → RAM_RE=1, RAM_RADDR from the winner, RAM_WE=0.
- No grant → WE=RE=0; address/data lines are don't-care but driven stably (last winner's values).

Read latency:
- Read accepted at edge t; primitive presents RAM_RDATA after edge t.
- Pipeline tag {valid, id} registered at edge t; RAM_RDATA captured into RDATA_id at edge t+1.
- RVALID_id high for the cycle following edge t+1: 2-cycle latency, fully pipelined.
- Back-to-back reads from the same or alternating requesters are legal.

Boundary conditions:
- Write at t then read of the same address at t+1 returns the new data (no bypass needed).
- Masked bits keep old contents.
- Address wrap: none; ADDR_W bits are used directly.
- RST mid-INIT: restart at counter 0.
- RST with a read in flight: tag cleared, no RVALID, RDATA_n = 0.
- REQ deasserted without grant: permitted, no side effects.

Decomposition:
- Package ram40_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum {ST_INIT, ST_RUN}.
  - Requester-id typedef (1 bit).
  - INIT_LAST = 2**ADDR_W-1.
- Sub-module ram40_rr_arb: 2-way grant logic plus last_gnt register, with FIXED_PRIO parameter and an accept input.
- Top holds the FSM, init counter, RAM muxing and the read-return pipeline.

Test Plan:
- Reset, INIT_CLEAR=1 → INIT_DONE rises exactly 256 cycles after RST falls; model shows all 256 words = 0x0000; no GNT during init.
- REQ_0 write addr 0x12 data 0xA5A5 mask 0x0000, then REQ_1 read 0x12 → RVALID_1 pulses 2 cycles after acceptance, RDATA_1 = 0xA5A5; RDATA_0 unchanged.
- Masked write addr 0x12 data 0xFFFF mask 0xFF00 over 0xA5A5 → read returns 0xA5FF.
- Both REQs held 6 cycles, round-robin → grants 0,1,0,1,0,1; with FIXED_PRIO=1 → six grants to 0, zero to 1.
- Back-to-back reads R0@0x01, R1@0x02, R0@0x03 (preloaded 0x1111/0x2222/0x3333) → RVALID pulses on consecutive cycles with matching data per requester.
- RST asserted one cycle after read acceptance → no RVALID, RDATA_n = 0, FSM back in INIT with counter 0.
